// File: rtl/jtag_tap_ctrl_pkg.sv
// rtl/jtag_tap_ctrl_pkg.sv - shared JTAG TAP state codes, widths and next-state graph
package jtag_tap_ctrl_pkg;

    localparam int TAP_STATE_W     = 4;
    localparam int TAP_STATE_COUNT = 16;
    localparam int IDCODE_W        = 32;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PAU_IR = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_e;

    // Standard IEEE 1149.1 graph; unknown codes fall back to Test-Logic-Reset.
    function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms);
        tap_state_e nxt;
        case (cur)
            TAP_TLR:    nxt = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: nxt = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: nxt = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: nxt = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: nxt = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: nxt = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: nxt = tms ? TAP_SEL_DR : TAP_RTI;
            default:    nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_state_machine.sv
// rtl/jtag_tap_state_machine.sv - 16-state TAP controller with registered state decodes
module jtag_tap_state_machine
    import jtag_tap_ctrl_pkg::*;
(
    input  logic                   tck,
    input  logic                   trstn,
    input  logic                   tms,
    output logic [TAP_STATE_W-1:0] state,
    output logic                   in_tlr,
    output logic                   in_cap_dr,
    output logic                   in_sh_dr,
    output logic                   in_upd_dr,
    output logic                   in_cap_ir,
    output logic                   in_sh_ir,
    output logic                   in_upd_ir
);

    tap_state_e state_q;
    tap_state_e state_nxt;

    assign state_nxt = tap_next(state_q, tms);
    assign state     = state_q;

    // Decodes are registered from the next state so they line up with state_q.
    always_ff @(posedge tck) begin
        if (!trstn) begin
            state_q   <= TAP_TLR;
            in_tlr    <= 1'b1;
            in_cap_dr <= 1'b0;
            in_sh_dr  <= 1'b0;
            in_upd_dr <= 1'b0;
            in_cap_ir <= 1'b0;
            in_sh_ir  <= 1'b0;
            in_upd_ir <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            in_tlr    <= (state_nxt == TAP_TLR);
            in_cap_dr <= (state_nxt == TAP_CAP_DR);
            in_sh_dr  <= (state_nxt == TAP_SH_DR);
            in_upd_dr <= (state_nxt == TAP_UPD_DR);
            in_cap_ir <= (state_nxt == TAP_CAP_IR);
            in_sh_ir  <= (state_nxt == TAP_SH_IR);
            in_upd_ir <= (state_nxt == TAP_UPD_IR);
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - JTAG TAP with IR, BYPASS, IDCODE and external user data registers
module jtag_tap_ctrl
    import jtag_tap_ctrl_pkg::*;
#(
    parameter int          IR_WIDTH       = 5,
    parameter logic [31:0] IDCODE_VALUE   = 32'h1000_0001,
    parameter int          IDCODE_INSN    = 'h01,
    parameter int          NR_USER        = 2,
    parameter int          USER_INSN_BASE = 'h08
) (
    input  logic                   tck,
    input  logic                   trstn,
    input  logic                   tms,
    input  logic                   tdi,
    output logic                   tdo,
    output logic                   tdo_oe,
    output logic [TAP_STATE_W-1:0] state,
    output logic [IR_WIDTH-1:0]    ir,
    output logic                   tlr,
    output logic [NR_USER-1:0]     user_sel,
    output logic                   user_capture,
    output logic                   user_shift,
    output logic                   user_update,
    input  logic [NR_USER-1:0]     user_tdo
);

    localparam logic [IR_WIDTH-1:0] IDCODE_IR = IR_WIDTH'(IDCODE_INSN);

    logic in_tlr, in_cap_dr, in_sh_dr, in_upd_dr, in_cap_ir, in_sh_ir, in_upd_ir;

    jtag_tap_state_machine u_fsm (
        .tck       (tck),
        .trstn     (trstn),
        .tms       (tms),
        .state     (state),
        .in_tlr    (in_tlr),
        .in_cap_dr (in_cap_dr),
        .in_sh_dr  (in_sh_dr),
        .in_upd_dr (in_upd_dr),
        .in_cap_ir (in_cap_ir),
        .in_sh_ir  (in_sh_ir),
        .in_upd_ir (in_upd_ir)
    );

    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic                bypass_q;
    logic [IDCODE_W-1:0] idcode_sr;
    logic                sel_idcode;
    logic                sel_user;
    logic                sel_bypass;
    logic [NR_USER-1:0]  user_dec;

    // Entering TLR through TMS takes effect immediately, not one edge later.
    assign ir  = in_tlr ? IDCODE_IR : ir_q;
    assign tlr = in_tlr;

    always_comb begin
        user_dec   = '0;
        sel_idcode = (ir == IDCODE_IR);
        for (int i = 0; i < NR_USER; i++) begin
            user_dec[i] = (ir == IR_WIDTH'(USER_INSN_BASE + i));
        end
        if (sel_idcode) begin
            user_dec = '0;
        end
    end

    assign sel_user   = |user_dec;
    assign sel_bypass = !sel_idcode && !sel_user;
    assign user_sel   = user_dec;

    assign user_capture = in_cap_dr && sel_user;
    assign user_shift   = in_sh_dr  && sel_user;
    assign user_update  = in_upd_dr && sel_user;
    assign tdo_oe       = in_sh_ir  || in_sh_dr;

    always_ff @(posedge tck) begin
        if (!trstn) begin
            ir_sr     <= '0;
            ir_q      <= IDCODE_IR;
            bypass_q  <= 1'b0;
            idcode_sr <= '0;
        end else begin
            if (in_cap_ir) begin
                ir_sr <= IR_WIDTH'(2'b01);
            end else if (in_sh_ir) begin
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            end

            if (in_tlr) begin
                ir_q <= IDCODE_IR;
            end else if (in_upd_ir) begin
                ir_q <= ir_sr;
            end

            if (sel_bypass && in_cap_dr) begin
                bypass_q <= 1'b0;
            end else if (sel_bypass && in_sh_dr) begin
                bypass_q <= tdi;
            end

            if (sel_idcode && in_cap_dr) begin
                idcode_sr <= IDCODE_VALUE;
            end else if (sel_idcode && in_sh_dr) begin
                idcode_sr <= {tdi, idcode_sr[IDCODE_W-1:1]};
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (in_sh_ir) begin
            tdo = ir_sr[0];
        end else if (in_sh_dr) begin
            if (sel_idcode) begin
                tdo = idcode_sr[0];
            end else if (sel_user) begin
                tdo = |(user_dec & user_tdo);
            end else begin
                tdo = bypass_q;
            end
        end
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5; instruction register width, minimum 2.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1000_0001; device ID, bit 0 SHALL be 1.
REQ-003 SHALL have parameter IDCODE_INSN, default 'h01; IDCODE opcode.
REQ-004 SHALL have parameter NR_USER, default 2; number of external user data registers, 1..8.
REQ-005 SHALL have parameter USER_INSN_BASE, default 'h08; opcode of user DR 0, user DR i = base+i.
REQ-006 SHALL have port tck, input, 1; the only clock, all state changes on rising edge.
REQ-007 SHALL have port trstn, input, 1; reset, synchronous, active-low.
REQ-008 SHALL have ports tms and tdi, input, 1 each; TAP mode select and serial data in.
REQ-009 SHALL have port tdo, output, 1; serial data out.
REQ-010 SHALL have port tdo_oe, output, 1; high in Shift-IR or Shift-DR.
REQ-011 SHALL have port state, output, 4; current TAP state code.
REQ-012 SHALL have port ir, output, IR_WIDTH; current (updated) instruction.
REQ-013 SHALL have port tlr, output, 1; high in Test-Logic-Reset.
REQ-014 SHALL have port user_sel, output, NR_USER; one-hot decode of the active user instruction, else 0.
REQ-015 SHALL have ports user_capture, user_shift, user_update, output, 1 each; high in Capture-DR / Shift-DR / Update-DR while any user_sel bit is set.
REQ-016 SHALL have port user_tdo, input, NR_USER; serial out of each user DR.

Function
REQ-017 SHALL implement the standard 16-state TAP graph with the team's existing 4-bit state codes (TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D).
REQ-018 SHALL reach TLR after at most 5 consecutive TMS=1 edges from any state, via the graph alone.
REQ-019 SHALL treat any non-listed state code as TLR next cycle.
REQ-020 Capture-IR SHALL load the IR shift register with bits[1:0]=2'b01, upper bits 0.
REQ-021 Shift-IR SHALL shift right: MSB<=tdi; tdo=IR shift bit 0 during Shift-IR, combinational.
REQ-022 Update-IR SHALL copy the IR shift register to ir; ir changes on the edge leaving Update-IR.
REQ-023 In TLR, ir SHALL be IDCODE_INSN.
REQ-024 Decode: ir==IDCODE_INSN selects IDCODE; ir in [USER_INSN_BASE, USER_INSN_BASE+NR_USER-1] selects that user DR; all other codes, including all-ones, select BYPASS.
REQ-025 BYPASS: 1-bit register, Capture-DR loads 0, Shift-DR loads tdi; tdo=bypass bit, giving one cycle of tdi->tdo delay.
REQ-026 IDCODE: 32-bit register, Capture-DR loads IDCODE_VALUE, Shift-DR shifts right with MSB<=tdi; tdo=bit 0, LSB first.
REQ-027 User DR selected: tdo=user_tdo[i]; the block holds no user data, strobes per REQ-015.
REQ-028 tdo SHALL be 0 when tdo_oe is 0.
REQ-029 Registers not addressed by the current state/instruction SHALL hold.
REQ-030 Pause states SHALL hold all shift registers.

Reset
REQ-031 trstn low at a tck edge SHALL force: state=TLR, ir=IDCODE_INSN, IR shift=0, bypass=0, IDCODE shift=0; next cycle outputs tdo_oe=0, tdo=0, tlr=1, user_* strobes 0, user_sel=0.
REQ-032 Reset mid-scan SHALL discard partial shift data without updating ir; reset dominates tms.

Structure
REQ-033 State codes, state-count and width constants SHALL reside in the shared JTAG TAP states package; parameter defaults stay in the module.
REQ-034 The state machine SHALL be one sub-module, jtag_tap_state_machine (tck, trstn, tms -> state, one-hot state decodes); IR, DR and decode logic stay in jtag_tap_ctrl.

Verification
REQ-035 Reset, TMS 0,1,0,0, then 32 ShDR cycles -> tdo emits 32'h1000_0001 LSB first; tdo_oe=1 for exactly 32 cycles.
REQ-036 IR scan shifting 5'h1F -> first two tdo bits 1,0; after UpdIR, ir=5'h1F; DR scan of 0xA5 LSB first -> tdo = 0 then 0xA5, delayed one cycle.
REQ-037 IR=5'h09 -> user_sel=2'b10; user_capture high 1 cycle in CapDR; user_shift high in each ShDR cycle; tdo tracks user_tdo[1]; user_update high 1 cycle.
REQ-038 IR=5'h05 (unassigned) -> bypass behaviour as in REQ-036, user_sel=0.
REQ-039 trstn low during 3rd ShIR cycle -> next state=F, ir=IDCODE_INSN, tdo_oe=0.
REQ-040 From PauDR, TMS=1 for 5 edges -> state=F, ir=IDCODE_INSN, user_update pulses once on the way.
